// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings for the memory access unit
package mau_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    // Error causes are one-hot so both can be reported together
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mau_addr_check.sv
// mau_addr_check: effective-address adder with alignment and range checks
module mau_addr_check
    import mau_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic [31:0] base,
    input  logic [15:0] offset,
    output logic [31:0] word_addr,
    output logic [1:0]  cause
);

    logic [31:0] ea;

    always_comb begin
        ea        = base + {{16{offset[15]}}, offset};
        word_addr = {2'b00, ea[31:2]};
        cause     = (ea[1:0] != 2'b00 ? ERR_MISALIGN : ERR_NONE)
                  | (word_addr >= 32'(MEM_WORDS) ? ERR_RANGE : ERR_NONE);
    end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: single-outstanding load/store controller for the data memory port
module memory_access_unit
    import mau_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    logic [1:0]       state;
    op_e              op_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      chk_addr;
    logic [1:0]       chk_cause;

    mau_addr_check #(.MEM_WORDS(MEM_WORDS)) u_chk (
        .base      (req_base),
        .offset    (req_offset),
        .word_addr (chk_addr),
        .cause     (chk_cause)
    );

    // Strobes decode from state so an async reset drops them immediately
    always_comb begin
        req_ready  = state == S_IDLE;
        memwrite   = state == S_ACCESS && op_q == OP_STORE && !err_q;
        memread    = state == S_ACCESS && op_q == OP_LOAD && !err_q;
        resp_valid = state == S_RESP;
        resp_err   = resp_valid && err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            op_q       <= OP_LOAD;
            err_q      <= 1'b0;
            cnt        <= '0;
            address    <= '0;
            writedata  <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state      <= S_ACCESS;
                        op_q       <= op_e'(req_write);
                        err_q      <= |chk_cause;
                        address    <= chk_addr;
                        writedata  <= req_wdata;
                        resp_rdata <= '0;
                    end
                end
                S_ACCESS: begin
                    state <= (err_q || op_q == OP_STORE) ? S_RESP : S_WAIT;
                    cnt   <= (err_q || op_q == OP_STORE) ? '0 : CNT_W'(RD_LAT);
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1) begin
                        resp_rdata <= readdata;
                        state      <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
